// File: rtl/auto_fifo_prefetch_pop_control_if.sv
// Handshake bundle between the prefetch pop controller, its source FIFO and the downstream consumer.
// The master side is the controller; the slave side is the FIFO/consumer environment.
interface auto_fifo_prefetch_pop_control_if #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned PrefetchDepth = 4
);
  localparam int unsigned OccWidth = $clog2(PrefetchDepth + 1);

  logic                 oPopSignal;
  logic                 iEmpty;
  logic [DataWidth-1:0] iFIFOData;
  logic [DataWidth-1:0] oData;
  logic                 oValid;
  logic                 iReady;
  logic [OccWidth-1:0]  oOccupancy;

  modport master (
    output oPopSignal,
    output oData,
    output oValid,
    output oOccupancy,
    input  iEmpty,
    input  iFIFOData,
    input  iReady
  );

  modport slave (
    input  oPopSignal,
    input  oData,
    input  oValid,
    input  oOccupancy,
    output iEmpty,
    output iFIFOData,
    output iReady
  );
endinterface

// File: rtl/auto_fifo_prefetch_pop_control.sv
// Credit-based pop controller for fixed-latency source FIFOs: pops ahead, lands returning
// words in a circular prefetch buffer and presents the head on a valid/ready port.
module auto_fifo_prefetch_pop_control #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned ReadLatency   = 1,
  parameter int unsigned PrefetchDepth = 4
) (
  input  logic iClock,
  input  logic iReset,
  auto_fifo_prefetch_pop_control_if.master bus
);
  localparam int unsigned PtrWidth = $clog2(PrefetchDepth);
  localparam int unsigned CntWidth = $clog2(PrefetchDepth + 1);
  localparam int unsigned SumWidth = CntWidth + 1;

  if (ReadLatency < 1 || ReadLatency > 4) begin : g_bad_latency
    $error("ReadLatency must be within 1..4");
  end
  if (PrefetchDepth < ReadLatency + 1 || (PrefetchDepth & (PrefetchDepth - 1)) != 0) begin : g_bad_depth
    $error("PrefetchDepth must be a power of two and at least ReadLatency+1");
  end

  logic [DataWidth-1:0]   storage [PrefetchDepth];
  logic [PtrWidth-1:0]    head;
  logic [PtrWidth-1:0]    tail;
  logic [CntWidth-1:0]    occupancy;
  logic [ReadLatency-1:0] inflight_sr;

  logic [CntWidth-1:0] inflight;
  logic [SumWidth-1:0] committed;
  logic                has_credit;
  logic                valid;
  logic                deq;
  logic                arrive;
  logic                pop;

  // Words popped but not yet landed, one bit per outstanding latency stage.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < ReadLatency; i++) begin
      inflight = inflight + CntWidth'(inflight_sr[i]);
    end
  end

  always_comb begin
    committed  = SumWidth'(occupancy) + SumWidth'(inflight);
    has_credit = committed < SumWidth'(PrefetchDepth);
    valid      = occupancy != '0;
    deq        = valid && bus.iReady;
    arrive     = inflight_sr[ReadLatency-1];
    // A same-cycle dequeue frees a slot, so it may cover a pop even with zero credit.
    pop        = !iReset && !bus.iEmpty && (has_credit || deq);
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      head        <= '0;
      tail        <= '0;
      occupancy   <= '0;
      inflight_sr <= '0;
      for (int unsigned i = 0; i < PrefetchDepth; i++) begin
        storage[i] <= '0;
      end
    end else begin
      inflight_sr[0] <= pop;
      for (int unsigned i = 1; i < ReadLatency; i++) begin
        inflight_sr[i] <= inflight_sr[i-1];
      end

      if (arrive) begin
        storage[tail] <= bus.iFIFOData;
        tail          <= tail + 1'b1;
      end

      if (deq) begin
        head <= head + 1'b1;
      end

      if (arrive && !deq) begin
        occupancy <= occupancy + 1'b1;
      end else if (deq && !arrive) begin
        occupancy <= occupancy - 1'b1;
      end
    end
  end

  assign bus.oPopSignal = pop;
  assign bus.oValid     = valid;
  assign bus.oData      = storage[head];
  assign bus.oOccupancy = occupancy;

endmodule

// File: tb/tb_auto_fifo_prefetch_pop_control.sv
// Directed bench for the prefetch pop controller: a two-cycle-latency source model, an
// independent occupancy/order model and per-scenario latency, throughput and backpressure checks.
module tb_auto_fifo_prefetch_pop_control;
  localparam int unsigned DataWidth     = 32;
  localparam int unsigned ReadLatency   = 2;
  localparam int unsigned PrefetchDepth = 4;

  logic iClock;
  logic iReset;

  auto_fifo_prefetch_pop_control_if #(
    .DataWidth    (DataWidth),
    .PrefetchDepth(PrefetchDepth)
  ) bus ();

  auto_fifo_prefetch_pop_control #(
    .DataWidth    (DataWidth),
    .ReadLatency  (ReadLatency),
    .PrefetchDepth(PrefetchDepth)
  ) u_dut (
    .iClock(iClock),
    .iReset(iReset),
    .bus   (bus)
  );

  int checks;
  int failures;
  int cycle;

  // Source FIFO model: words remaining, next word, and the two-stage read pipeline.
  int          src_count;
  logic [31:0] src_next;
  logic        gap;
  logic        ready;
  logic        pend_v;
  logic [31:0] pend_w;
  logic        s1_v;
  logic [31:0] s1_w;
  logic        s2_v;
  logic [31:0] s2_w;

  // Consumer-side model.
  int          tb_occ;
  logic [31:0] exp_next;
  logic        prev_hold;
  logic [31:0] prev_data;
  int          pops;
  int          deqs;
  int          first_pop;
  int          last_pop;
  int          first_deq;
  int          last_deq;
  logic [31:0] first_deq_word;
  logic [31:0] last_deq_word;

  initial begin
    iClock = 1'b0;
    forever #5 iClock = ~iClock;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  task automatic clear_counters();
    pops      = 0;
    deqs      = 0;
    first_pop = -1;
    last_pop  = -1;
    first_deq = -1;
    last_deq  = -1;
    first_deq_word = '0;
    last_deq_word  = '0;
  endtask

  task automatic clear_model();
    tb_occ    = 0;
    pend_v    = 1'b0;
    s1_v      = 1'b0;
    s2_v      = 1'b0;
    prev_hold = 1'b0;
  endtask

  // Sample outputs mid-cycle and advance the reference model by one clock.
  task automatic sample();
    logic deq;
    logic exp_pop;
    int   committed;
    if (iReset) begin
      check_eq("rst_pop",   32'(bus.oPopSignal), 32'd0);
      check_eq("rst_valid", 32'(bus.oValid),     32'd0);
      check_eq("rst_occ",   32'(bus.oOccupancy), 32'd0);
      check_eq("rst_data",  bus.oData,           32'd0);
      clear_model();
      return;
    end
    deq       = bus.oValid && bus.iReady;
    committed = tb_occ + int'(s1_v) + int'(s2_v);
    exp_pop   = !bus.iEmpty && ((committed < int'(PrefetchDepth)) || (tb_occ != 0 && ready));
    check_eq("occupancy", 32'(bus.oOccupancy), 32'(tb_occ));
    check_eq("valid",     32'(bus.oValid),     32'(tb_occ != 0));
    check_eq("invariant", 32'(int'(bus.oOccupancy) + int'(s1_v) + int'(s2_v) <= int'(PrefetchDepth)), 32'd1);
    check_eq("pop",       32'(bus.oPopSignal), 32'(exp_pop));
    if (prev_hold) begin
      check_eq("hold_valid", 32'(bus.oValid), 32'd1);
      check_eq("hold_data",  bus.oData,       prev_data);
    end
    if (deq) begin
      check_eq("order", bus.oData, exp_next);
      exp_next = exp_next + 32'd1;
      if (first_deq < 0) begin
        first_deq      = cycle;
        first_deq_word = bus.oData;
      end
      last_deq      = cycle;
      last_deq_word = bus.oData;
      deqs++;
    end
    if (bus.oPopSignal) begin
      pend_v   = 1'b1;
      pend_w   = src_next;
      src_next = src_next + 32'd1;
      if (src_count > 0) src_count--;
      if (first_pop < 0) first_pop = cycle;
      last_pop = cycle;
      pops++;
    end
    tb_occ    = tb_occ + int'(s2_v) - int'(deq);
    prev_hold = bus.oValid && !bus.iReady;
    prev_data = bus.oData;
  endtask

  task automatic step();
    @(posedge iClock);
    #1;
    cycle++;
    s2_v = s1_v;
    s2_w = s1_w;
    s1_v = pend_v;
    s1_w = pend_w;
    pend_v = 1'b0;
    bus.iFIFOData = s2_v ? s2_w : 32'hDEAD_BEEF;
    bus.iEmpty    = (src_count == 0) || gap;
    bus.iReady    = ready;
    @(negedge iClock);
    sample();
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (deqs < target && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, 32'(deqs), 32'(target));
  endtask

  task automatic start_scenario(input int words, input logic [31:0] base, input logic rdy);
    clear_counters();
    src_count = words;
    src_next  = base;
    exp_next  = base;
    ready     = rdy;
    gap       = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cycle     = 0;
    iReset    = 1'b1;
    bus.iEmpty    = 1'b1;
    bus.iReady    = 1'b0;
    bus.iFIFOData = '0;
    pend_w    = '0;
    s1_w      = '0;
    s2_w      = '0;
    prev_data = '0;
    clear_model();
    start_scenario(0, 32'h100, 1'b0);

    // Reset held for three cycles, then idle with an empty source.
    repeat (3) step();
    iReset = 1'b0;
    repeat (5) step();
    check_eq("idle_pops", 32'(pops), 32'd0);

    // Single word: one pop, data valid three cycles later.
    start_scenario(1, 32'h100, 1'b1);
    repeat (8) step();
    check_eq("single_pops",    32'(pops),                32'd1);
    check_eq("single_deqs",    32'(deqs),                32'd1);
    check_eq("single_latency", 32'(first_deq - first_pop), 32'd3);
    check_eq("single_word",    first_deq_word,           32'h100);
    check_eq("single_occ_end", 32'(bus.oOccupancy),      32'd0);

    // Streaming at full rate.
    start_scenario(64, 32'h100, 1'b1);
    run_until(64, 200, "stream_done");
    check_eq("stream_pops",      32'(pops),                 32'd64);
    check_eq("stream_pop_span",  32'(last_pop - first_pop), 32'd63);
    check_eq("stream_deq_span",  32'(last_deq - first_deq), 32'd63);
    check_eq("stream_last_word", last_deq_word,             32'h13F);
    repeat (4) step();

    // Backpressure: fill to depth, then release.
    start_scenario(10, 32'h100, 1'b0);
    repeat (10) step();
    check_eq("bp_pops",      32'(pops),            32'd4);
    check_eq("bp_occ",       32'(bus.oOccupancy),  32'd4);
    check_eq("bp_pop_quiet", 32'(bus.oPopSignal),  32'd0);
    ready = 1'b1;
    run_until(10, 100, "bp_done");
    check_eq("bp_total_pops", 32'(pops),       32'd10);
    check_eq("bp_last_word",  last_deq_word,   32'h109);
    repeat (4) step();

    // Random ready and source gaps.
    start_scenario(1000, 32'h100, 1'b0);
    begin
      int n;
      n = 0;
      while (deqs < 1000 && n < 20000) begin
        ready = 1'($urandom_range(0, 1));
        gap   = ($urandom_range(0, 3) == 0);
        step();
        n++;
      end
    end
    check_eq("rand_done", 32'(deqs), 32'd1000);
    check_eq("rand_pops", 32'(pops), 32'd1000);
    gap   = 1'b0;
    ready = 1'b1;
    repeat (6) step();

    // Asynchronous reset with two words in flight.
    start_scenario(20, 32'h100, 1'b1);
    begin
      int n;
      n = 0;
      while (!(s1_v && s2_v) && n < 20) begin
        step();
        n++;
      end
    end
    check_eq("rst_two_inflight", 32'(s1_v && s2_v), 32'd1);
    #2;
    iReset = 1'b1;
    #1;
    check_eq("async_valid", 32'(bus.oValid),     32'd0);
    check_eq("async_occ",   32'(bus.oOccupancy), 32'd0);
    check_eq("async_pop",   32'(bus.oPopSignal), 32'd0);
    check_eq("async_data",  bus.oData,           32'd0);
    clear_model();
    src_count = 0;
    repeat (2) step();
    start_scenario(5, 32'h200, 1'b1);
    iReset = 1'b0;
    run_until(5, 60, "post_rst_done");
    check_eq("post_rst_first", first_deq_word, 32'h200);
    check_eq("post_rst_last",  last_deq_word,  32'h204);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
